sprite_datapath: RTL

SPRITE_DATAPATH -- requirements
Module: sprite_datapath

---
 rtl/sprite_datapath.sv | 127 ++++++++++++
 1 files changed

// File: rtl/sprite_datapath.sv
`default_nettype none
// ============================================================================
// Module   : sprite_datapath
// Purpose  : Sprite position/direction registers plus a SIZE x SIZE pixel
//            scanner that feeds x/y/colour to a VGA adapter.
// Revision : 1.0 - initial release
// ============================================================================
module sprite_datapath #(
  parameter int          SIZE         = 16,
  parameter int          SCREEN_W     = 160,
  parameter int          SCREEN_H     = 120,
  parameter int          INIT_X       = 0,
  parameter int          INIT_Y       = 0,
  parameter logic [2:0]  DRAW_COLOUR  = 3'b111,
  parameter logic [2:0]  ERASE_COLOUR = 3'b000,
  parameter logic [2:0]  OVER_COLOUR  = 3'b100
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       datapath_en_i,
  input  logic [1:0] op_i,
  input  logic       move_en_i,
  input  logic [1:0] dir_i,
  input  logic       load_coord_i,
  output logic [7:0] x_o,
  output logic [6:0] y_o,
  output logic [2:0] colour_o,
  output logic       pixel_valid_o,
  output logic       done_o,
  output logic       touch_edge_o
);

  localparam int         LOG2  = $clog2(SIZE);
  localparam int         CW    = 2 * LOG2;
  localparam logic [7:0] MAX_X = 8'(SCREEN_W - SIZE);
  localparam logic [6:0] MAX_Y = 7'(SCREEN_H - SIZE);

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'b00,
    DIR_LEFT  = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_UP    = 2'b11
  } dir_e;

  dir_e            dir_q;
  logic [7:0]      pos_x_q, pos_x_d;
  logic [6:0]      pos_y_q, pos_y_d;
  logic            blocked;
  logic            touch_q;
  logic [CW-1:0]   cnt_q;
  logic [LOG2-1:0] col, row;
  logic [2:0]      colour_sel;
  logic [7:0]      x_q;
  logic [6:0]      y_q;
  logic [2:0]      colour_q;
  logic            valid_q;
  logic            done_q;

  // Candidate position for one step; a blocked step leaves the position as is.
  always_comb begin
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    blocked = 1'b0;
    case (dir_q)
      DIR_RIGHT: if (pos_x_q >= MAX_X) blocked = 1'b1; else pos_x_d = pos_x_q + 8'd1;
      DIR_LEFT:  if (pos_x_q == 8'd0)  blocked = 1'b1; else pos_x_d = pos_x_q - 8'd1;
      DIR_DOWN:  if (pos_y_q >= MAX_Y) blocked = 1'b1; else pos_y_d = pos_y_q + 7'd1;
      default:   if (pos_y_q == 7'd0)  blocked = 1'b1; else pos_y_d = pos_y_q - 7'd1;
    endcase
  end

  always_comb begin
    colour_sel = ERASE_COLOUR;
    case (op_i)
      2'b00:   colour_sel = DRAW_COLOUR;
      2'b10:   colour_sel = OVER_COLOUR;
      default: colour_sel = ERASE_COLOUR;
    endcase
  end

  assign col = cnt_q[LOG2-1:0];
  assign row = cnt_q[CW-1:LOG2];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pos_x_q  <= 8'(INIT_X);
      pos_y_q  <= 7'(INIT_Y);
      dir_q    <= DIR_RIGHT;
      touch_q  <= 1'b0;
      cnt_q    <= '0;
      x_q      <= 8'd0;
      y_q      <= 7'd0;
      colour_q <= ERASE_COLOUR;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      if (move_en_i) begin
        dir_q <= dir_e'(dir_i);
      end
      if (load_coord_i) begin
        pos_x_q <= pos_x_d;
        pos_y_q <= pos_y_d;
        touch_q <= blocked;
      end
      // Counter width is exactly 2*log2(SIZE), so the increment wraps by itself.
      if (datapath_en_i) begin
        cnt_q <= cnt_q + CW'(1);
      end else begin
        cnt_q <= '0;
      end
      x_q      <= pos_x_q + {{(8-LOG2){1'b0}}, col};
      y_q      <= pos_y_q + {{(7-LOG2){1'b0}}, row};
      colour_q <= colour_sel;
      valid_q  <= datapath_en_i;
      done_q   <= datapath_en_i && (cnt_q == {CW{1'b1}});
    end
  end

  assign x_o           = x_q;
  assign y_o           = y_q;
  assign colour_o      = colour_q;
  assign pixel_valid_o = valid_q;
  assign done_o        = done_q;
  assign touch_edge_o  = touch_q;

endmodule
`default_nettype wire
